// File: rtl/ex_muldiv_ctrl.sv
// Multi-cycle EX-stage multiply / unsigned divide controller.
// Runs one shift-add or restoring-division step per cycle and stalls the pipeline while busy.
module ex_muldiv_ctrl #(
  parameter logic [1:0] OP_MUL  = 2'd0,
  parameter logic [1:0] OP_DIVU = 2'd1,
  parameter logic [1:0] OP_REMU = 2'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        stall_req
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [1:0]  op_q;
  logic [31:0] acc_q;     // product accumulator or partial remainder
  logic [31:0] a_q;       // multiplicand, or dividend shifting out / quotient shifting in
  logic [31:0] b_q;       // multiplier or divisor
  logic [31:0] result_q;

  logic [31:0] acc_d, a_d, b_d, fin_d;
  logic [32:0] shifted, trial;
  logic        ge;

  always_comb begin
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    fin_d   = '0;
    shifted = {acc_q, a_q[31]};
    trial   = shifted - {1'b0, b_q};
    // remainder < divisor bounds shifted below 2*divisor, so bit 32 is exactly the borrow
    ge      = ~trial[32];
    if (op_q == OP_MUL) begin
      acc_d = acc_q + (b_q[0] ? a_q : '0);
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      fin_d = acc_d;
    end else begin
      acc_d = ge ? trial[31:0] : shifted[31:0];
      a_d   = {a_q[30:0], ge};
      fin_d = (op_q == OP_DIVU) ? a_d : acc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !flush) begin
            op_q  <= op;
            a_q   <= op1;
            b_q   <= op2;
            acc_q <= '0;
            cnt_q <= '0;
            if (op == OP_MUL || ((op == OP_DIVU || op == OP_REMU) && op2 != '0)) begin
              state_q <= BUSY;
            end else begin
              state_q <= DONE;
              if (op == OP_DIVU)      result_q <= '1;
              else if (op == OP_REMU) result_q <= op1;
              else                    result_q <= '0;
            end
          end
        end
        BUSY: begin
          if (flush) begin
            state_q <= IDLE;
          end else begin
            acc_q <= acc_d;
            a_q   <= a_d;
            b_q   <= b_d;
            if (cnt_q == 5'd31) begin
              state_q  <= DONE;
              result_q <= fin_d;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q == BUSY);
  assign done      = (state_q == DONE) && !flush;
  assign result    = result_q;
  assign stall_req = rst_n && (((state_q == IDLE) && start && !flush) || (state_q == BUSY));

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Self-checking bench for ex_muldiv_ctrl: directed corner cases plus random ops vs. an arithmetic model.
module tb_ex_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [1:0]  op;
  logic [31:0] op1, op2;
  logic        busy, done, stall_req;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_res;

  ex_muldiv_ctrl #(.OP_MUL(2'd0), .OP_DIVU(2'd1), .OP_REMU(2'd2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .op1(op1), .op2(op2),
    .flush(flush), .busy(busy), .done(done), .result(result), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      2'd0:    return a * b;
      2'd1:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'd2:    return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [31:0] b);
    return (o == 2'd3 || (o != 2'd0 && b == 0)) ? 1 : 33;
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int cyc, nbusy, lat;
    logic [31:0] exp;
    exp = model_res(o, a, b);
    lat = model_lat(o, b);
    @(negedge clk);
    start = 1'b1; op = o; op1 = a; op2 = b; flush = 1'b0;
    #1 check("stall_on_start", {31'b0, stall_req}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 1; nbusy = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) nbusy++;
      start = 1'($urandom_range(0, 1));
      op = 2'($urandom); op1 = $urandom; op2 = $urandom;
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, lat);
    check("busy_cycles", nbusy, lat - 1);
    check("result", result, exp);
    check("busy_in_done", {31'b0, busy}, 32'd0);
    start = 1'b1;
    #1 check("stall_in_done", {31'b0, stall_req}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("done_one_cycle", {31'b0, done}, 32'd0);
    check("start_in_done_ignored", {31'b0, busy}, 32'd0);
    check("result_held", result, exp);
    last_res = exp;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sawdone, sawbusy;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; op1 = '0; op2 = '0;
    last_res = '0;
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_stall", {31'b0, stall_req}, 32'd0);
    check("rst_result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(2'd0, 32'd7, 32'd6);
    run_op(2'd0, 32'hFFFF_FFFF, 32'd2);
    run_op(2'd1, 32'd100, 32'd7);
    run_op(2'd2, 32'd100, 32'd7);
    run_op(2'd1, 32'd5, 32'd0);
    run_op(2'd2, 32'd5, 32'd0);
    run_op(2'd3, 32'd123, 32'd45);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'd2, 32'd3, 32'hFFFF_FFF0);

    // flush at iteration 10, with a competing start in the same cycle
    @(negedge clk);
    start = 1'b1; op = 2'd1; op1 = 32'd1000; op2 = 32'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("busy_before_flush", {31'b0, busy}, 32'd1);
    flush = 1'b1; start = 1'b1; op = 2'd0; op1 = 32'd3; op2 = 32'd3;
    @(negedge clk);
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_done", {31'b0, done}, 32'd0);
    check("flush_result", result, last_res);
    flush = 1'b0; start = 1'b0;
    sawdone = 0; sawbusy = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) sawdone++;
      if (busy === 1'b1) sawbusy++;
      @(negedge clk);
    end
    check("flush_no_done", sawdone, 0);
    check("flush_start_ignored", sawbusy, 0);

    // asynchronous reset at iteration 20
    start = 1'b1; op = 2'd1; op1 = 32'd77; op2 = 32'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("busy_before_reset", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    check("arst_stall", {31'b0, stall_req}, 32'd0);
    check("arst_result", result, 32'd0);
    sawdone = 0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) sawdone++;
    end
    check("arst_no_done", sawdone, 0);
    rst_n = 1'b1;
    run_op(2'd1, 32'd9, 32'd3);

    for (int n = 0; n < 20; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      run_op(ro, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
